// File: rtl/wm_pkg.sv
// wm_pkg: shared load encodings, lock FSM states and defaults for the washing machine panel.
package wm_pkg;
  localparam logic [1:0] LOAD_SMALL  = 2'b00;
  localparam logic [1:0] LOAD_MEDIUM = 2'b01;
  localparam logic [1:0] LOAD_LARGE  = 2'b10;
  localparam logic [1:0] LOAD_RSVD   = 2'b11;
  localparam int DEBOUNCE_DEFAULT = 16;
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  function automatic logic [1:0] sat_load(input logic [1:0] l);
    return l == LOAD_RSVD ? LOAD_LARGE : l;
  endfunction
endpackage

// File: rtl/wm_debounce.sv
// wm_debounce: 2-FF synchroniser plus stable-count debouncer for one raw bit.
module wm_debounce
  import wm_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, flip;
  logic [W-1:0] cnt;
  assign flip = (s2 != stable) && cnt == W'(DEBOUNCE_CYCLES - 1);
  // rise is combinational so the parent can register its pulse on the same edge stable flips
  assign rise = flip && !stable;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= RST_VAL;
      s2     <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= flip ? ~stable : stable;
      cnt    <= (s2 == stable || flip) ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/wm_panel_input.sv
// wm_panel_input: debounced door/start/load panel inputs with start interlock and load freezing.
module wm_panel_input
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_raw,
  input  logic       start_raw,
  input  logic [1:0] load_raw,
  input  logic       cycle_done,
  output logic       door,
  output logic       start,
  output logic [1:0] load,
  output logic       locked
);
  logic start_stable, start_rise;
  logic [1:0] load_stable, cap;
  logic [2:0] unused_rise;
  lock_t state;
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_door (
    .clk(clk), .reset(reset), .raw(door_raw), .stable(door), .rise(unused_rise[2]));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_start (
    .clk(clk), .reset(reset), .raw(start_raw), .stable(start_stable), .rise(start_rise));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_load1 (
    .clk(clk), .reset(reset), .raw(load_raw[1]), .stable(load_stable[1]), .rise(unused_rise[1]));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_load0 (
    .clk(clk), .reset(reset), .raw(load_raw[0]), .stable(load_stable[0]), .rise(unused_rise[0]));
  assign locked = state == LOCKED;
  assign load   = locked ? cap : sat_load(load_stable);
  // start edges while locked or with the door open are dropped, never queued
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNLOCKED;
      start <= 1'b0;
      cap   <= LOAD_SMALL;
    end else begin
      start <= start_rise && !door && state == UNLOCKED;
      cap   <= state == LOCKED ? cap : sat_load(load_stable);
      state <= state == UNLOCKED ? (start ? LOCKED : UNLOCKED) : (cycle_done ? UNLOCKED : LOCKED);
    end
  end
endmodule
